ex_mem_redirect_buffer: RTL and testbench
=========================================

// Module: ex_mem_redirect_buffer
// PURPOSE
//  EX/MEM pipeline register with redirect generation. It latches ALU results and control for
//  the MEM stage and resolves PC redirects: vectored IRQ, taken branch, JALR, return-from-IRQ.
//  Successor to the single-IRQ, fixed-flush buffer. Adds NUM_IRQ prioritised vectored
//  interrupts, stall/valid handshake, a FLUSH_CYCLES squash window and an in-service interlock.
// PARAMETERS
//  REG_WIDTH       4   register-index width
//  BIT_WIDTH       32  datapath/address width
//  CTRL_BIT_WIDTH  5   ctrlIn width: [4]memtoReg [3]memWrite [2]branch [1]jalr [0]regWrite
//  NUM_IRQ         4   interrupt lines, index 0 = highest priority
//  VEC_STRIDE      16  bytes between handler vectors; power of two
//  FLUSH_CYCLES    1   squash-window length after a redirect; >= 1
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          asynchronous, active-low reset
//  stall        in   1          1 = hold every register and counter
//  inValid      in   1          EX slot holds a real instruction
//  irq          in   NUM_IRQ    level requests; source holds until irqAck
//  nextDrIn     in   REG_WIDTH  destination register
//  dFromAlu     in   BIT_WIDTH  ALU result, also branch condition and JALR target
//  sr2FromAlu   in   BIT_WIDTH  store data
//  branchIn     in   BIT_WIDTH  branch target
//  pipePcIn     in   BIT_WIDTH  PC+4 of the EX instruction
//  ctrlIn       in   CTRL_BIT_WIDTH  decoded control
//  retIn        in   1          EX instruction is RETI
//  IRA          in   BIT_WIDTH  saved interrupt return address
//  ihaBase      in   BIT_WIDTH  vector table base
//  outValid     out  1          MEM slot valid
//  nextDrOut, dPipeAluOut, dSr2Out, pipePcOut  out  registered copies of the inputs
//  memtoReg, memWrite, regWrite  out  1 each    MEM/WB control
//  branchOut    out  BIT_WIDTH  redirect target
//  pcMux        out  1          1 = fetch from branchOut
//  jal          out  1          1 = write link (pipePcOut) to the register file
//  flush        out  1          squash window active
//  irqAck       out  NUM_IRQ    one-hot, single-cycle acknowledge
//  inService    out  1          handler active; blocks further IRQs
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs, squash counter and inService go to 0.
//  - Latency: 1 cycle from the EX inputs to every output.
//  - stall=1: all outputs, the counter and inService hold; irqAck=0; no redirect is evaluated.
//  - Squash counter sq: loads FLUSH_CYCLES on any redirect. It decrements on each non-stalled
//    cycle while nonzero; flush = (sq != 0).
//  - While flush=1 the incoming slot is squashed: outValid, memWrite and regWrite are 0 and no
//    redirect is taken. IRQ is deferred and retIn is ignored (inService unchanged).
//  - Otherwise outValid=inValid. memWrite=ctrlIn[3]&inValid and regWrite=ctrlIn[0]&inValid.
//    Data and memtoReg always copy.
//  - Redirect priority, only when !flush & inValid & !stall:
//    1 IRQ: needs |irq and !inService. k = lowest set index.
//      branchOut = ihaBase + k*VEC_STRIDE (mod 2^BIT_WIDTH); pcMux=1, jal=0, irqAck[k]=1,
//      inService<=1. The EX instruction still commits.
//    2 branch: ctrlIn[2] and dFromAlu != 0. branchOut=branchIn, pcMux=1, jal=0.
//    3 JALR: ctrlIn[1]. branchOut=dFromAlu, pcMux=1, jal=1.
//    4 RETI: retIn. branchOut=IRA, pcMux=1, jal=0, inService<=0.
//    else: branchOut=0, pcMux=0, jal=0.
//  - branchOut, pcMux, jal and irqAck are single-cycle pulses. They clear the next cycle
//    unless stalled.
//  - IRQ with retIn and inService=0: IRQ wins and retIn is dropped.
//  - irq arriving with inService=1 stays pending until RETI clears inService.
//  - Reset mid-window clears sq immediately; there is no residual squash after reset.
// TESTING
//  - Reset: drive random inputs with rst=0 -> every output 0. Release rst -> first valid op
//    appears 1 cycle later.
//  - Branch: ctrlIn=5'b00100, dFromAlu=1, branchIn=0x100 -> pcMux=1, branchOut=0x100, jal=0.
//    FLUSH_CYCLES=2 -> flush=1 for 2 cycles, memWrite/regWrite=0 in both.
//  - Priority: irq=4'b0110, ihaBase=0x8000, plus a taken branch -> branchOut=0x8010,
//    irqAck=4'b0010, inService=1.
//  - Interlock: inService=1, irq=4'b0001 -> no redirect. retIn with IRA=0x44 -> branchOut=0x44,
//    inService=0. irq=4'b0001 is then taken on the next eligible cycle.
//  - Stall: stall=1 during a squash window -> sq, flush and outputs frozen. Release -> counting
//    resumes with no cycle lost.
//  - Wrap: ihaBase=0xFFFFFFF0, irq[1] -> branchOut=0x00000000.

Source files
------------

// File: rtl/ex_mem_redirect_buffer_if.sv
// ex_mem_redirect_buffer_if: EX-side inputs and MEM-side outputs of the EX/MEM redirect buffer.
interface ex_mem_redirect_buffer_if #(
    parameter int REG_WIDTH      = 4,
    parameter int BIT_WIDTH      = 32,
    parameter int CTRL_BIT_WIDTH = 5,
    parameter int NUM_IRQ        = 4
);
    logic                      stall_i;
    logic                      in_valid_i;
    logic [NUM_IRQ-1:0]        irq_i;
    logic [REG_WIDTH-1:0]      next_dr_i;
    logic [BIT_WIDTH-1:0]      d_alu_i;
    logic [BIT_WIDTH-1:0]      sr2_i;
    logic [BIT_WIDTH-1:0]      branch_i;
    logic [BIT_WIDTH-1:0]      pipe_pc_i;
    logic [CTRL_BIT_WIDTH-1:0] ctrl_i;
    logic                      ret_i;
    logic [BIT_WIDTH-1:0]      ira_i;
    logic [BIT_WIDTH-1:0]      iha_base_i;
    logic                      out_valid_o;
    logic [REG_WIDTH-1:0]      next_dr_o;
    logic [BIT_WIDTH-1:0]      d_alu_o;
    logic [BIT_WIDTH-1:0]      sr2_o;
    logic [BIT_WIDTH-1:0]      pipe_pc_o;
    logic                      mem_to_reg_o;
    logic                      mem_write_o;
    logic                      reg_write_o;
    logic [BIT_WIDTH-1:0]      branch_o;
    logic                      pc_mux_o;
    logic                      jal_o;
    logic                      flush_o;
    logic [NUM_IRQ-1:0]        irq_ack_o;
    logic                      in_service_o;

    modport master (
        output stall_i, in_valid_i, irq_i, next_dr_i, d_alu_i, sr2_i, branch_i, pipe_pc_i,
               ctrl_i, ret_i, ira_i, iha_base_i,
        input  out_valid_o, next_dr_o, d_alu_o, sr2_o, pipe_pc_o, mem_to_reg_o, mem_write_o,
               reg_write_o, branch_o, pc_mux_o, jal_o, flush_o, irq_ack_o, in_service_o
    );
    modport slave (
        input  stall_i, in_valid_i, irq_i, next_dr_i, d_alu_i, sr2_i, branch_i, pipe_pc_i,
               ctrl_i, ret_i, ira_i, iha_base_i,
        output out_valid_o, next_dr_o, d_alu_o, sr2_o, pipe_pc_o, mem_to_reg_o, mem_write_o,
               reg_write_o, branch_o, pc_mux_o, jal_o, flush_o, irq_ack_o, in_service_o
    );
endinterface

// File: rtl/ex_mem_redirect_buffer.sv
// ex_mem_redirect_buffer: EX/MEM pipeline register resolving vectored IRQ, branch, JALR and
// RETI redirects, with a squash window after each redirect and an in-service interlock.
module ex_mem_redirect_buffer #(
    parameter int REG_WIDTH      = 4,
    parameter int BIT_WIDTH      = 32,
    parameter int CTRL_BIT_WIDTH = 5,
    parameter int NUM_IRQ        = 4,
    parameter int VEC_STRIDE     = 16,
    parameter int FLUSH_CYCLES   = 1
) (
    input logic clk,
    input logic rst_n,
    ex_mem_redirect_buffer_if.slave bus
);
    localparam int SQW = $clog2(FLUSH_CYCLES + 1);

    logic [SQW-1:0]       sq_q, sq_d;
    logic                 in_service_q, in_service_d;
    logic                 valid_q, valid_d;
    logic [REG_WIDTH-1:0] next_dr_q, next_dr_d;
    logic [BIT_WIDTH-1:0] d_alu_q, d_alu_d, sr2_q, sr2_d, pipe_pc_q, pipe_pc_d;
    logic                 mem_to_reg_q, mem_to_reg_d, mem_write_q, mem_write_d;
    logic                 reg_write_q, reg_write_d;
    logic [BIT_WIDTH-1:0] branch_q, branch_d;
    logic                 pc_mux_q, pc_mux_d, jal_q, jal_d;
    logic [NUM_IRQ-1:0]   ack_q, ack_d, irq_onehot;
    logic [BIT_WIDTH-1:0] vec;
    logic                 squash, live, irq_go, br_go, jalr_go, ret_go;

    always_comb begin
        vec        = '0;
        irq_onehot = '0;
        // Descending scan so the lowest set line is the one that sticks.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (bus.irq_i[i]) begin
                vec        = bus.iha_base_i + BIT_WIDTH'(i * VEC_STRIDE);
                irq_onehot = NUM_IRQ'(1) << i;
            end
        end
    end

    always_comb begin
        squash       = sq_q != '0;
        live         = !squash && bus.in_valid_i;
        irq_go       = live && |bus.irq_i && !in_service_q;
        br_go        = live && !irq_go && bus.ctrl_i[2] && |bus.d_alu_i;
        jalr_go      = live && !irq_go && !br_go && bus.ctrl_i[1];
        ret_go       = live && !irq_go && !br_go && !jalr_go && bus.ret_i;
        valid_d      = live;
        mem_write_d  = live && bus.ctrl_i[3];
        reg_write_d  = live && bus.ctrl_i[0];
        mem_to_reg_d = bus.ctrl_i[4];
        next_dr_d    = bus.next_dr_i;
        d_alu_d      = bus.d_alu_i;
        sr2_d        = bus.sr2_i;
        pipe_pc_d    = bus.pipe_pc_i;
        branch_d     = irq_go ? vec : br_go ? bus.branch_i : jalr_go ? bus.d_alu_i :
                       ret_go ? bus.ira_i : '0;
        pc_mux_d     = irq_go || br_go || jalr_go || ret_go;
        jal_d        = jalr_go;
        ack_d        = irq_go ? irq_onehot : '0;
        in_service_d = irq_go ? 1'b1 : ret_go ? 1'b0 : in_service_q;
        sq_d         = pc_mux_d ? SQW'(FLUSH_CYCLES) : squash ? sq_q - SQW'(1) : sq_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_q         <= '0;
            in_service_q <= 1'b0;
            valid_q      <= 1'b0;
            next_dr_q    <= '0;
            d_alu_q      <= '0;
            sr2_q        <= '0;
            pipe_pc_q    <= '0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            branch_q     <= '0;
            pc_mux_q     <= 1'b0;
            jal_q        <= 1'b0;
            ack_q        <= '0;
        end else if (bus.stall_i) begin
            ack_q        <= '0;
        end else begin
            sq_q         <= sq_d;
            in_service_q <= in_service_d;
            valid_q      <= valid_d;
            next_dr_q    <= next_dr_d;
            d_alu_q      <= d_alu_d;
            sr2_q        <= sr2_d;
            pipe_pc_q    <= pipe_pc_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            branch_q     <= branch_d;
            pc_mux_q     <= pc_mux_d;
            jal_q        <= jal_d;
            ack_q        <= ack_d;
        end
    end

    assign bus.out_valid_o  = valid_q;
    assign bus.next_dr_o    = next_dr_q;
    assign bus.d_alu_o      = d_alu_q;
    assign bus.sr2_o        = sr2_q;
    assign bus.pipe_pc_o    = pipe_pc_q;
    assign bus.mem_to_reg_o = mem_to_reg_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.reg_write_o  = reg_write_q;
    assign bus.branch_o     = branch_q;
    assign bus.pc_mux_o     = pc_mux_q;
    assign bus.jal_o        = jal_q;
    assign bus.flush_o      = sq_q != '0;
    assign bus.irq_ack_o    = ack_q;
    assign bus.in_service_o = in_service_q;
endmodule

// File: tb/tb_ex_mem_redirect_buffer.sv
// tb_ex_mem_redirect_buffer: directed scenarios plus randomized traffic against a
// cycle-level reference model of the redirect buffer.
module tb_ex_mem_redirect_buffer;
    localparam int RW = 4, BW = 32, CW = 5, NI = 4, VS = 16, FC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ex_mem_redirect_buffer_if #(.REG_WIDTH(RW), .BIT_WIDTH(BW), .CTRL_BIT_WIDTH(CW), .NUM_IRQ(NI)) bus ();

    ex_mem_redirect_buffer #(
        .REG_WIDTH(RW), .BIT_WIDTH(BW), .CTRL_BIT_WIDTH(CW),
        .NUM_IRQ(NI), .VEC_STRIDE(VS), .FLUSH_CYCLES(FC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // reference model state and expected outputs
    int          m_sq;
    bit          m_insvc;
    bit          e_valid, e_m2r, e_mw, e_rw, e_pcm, e_jal;
    logic [3:0]  e_dr;
    logic [31:0] e_d, e_sr2, e_pc, e_br;
    logic [3:0]  e_ack;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sq = 0; m_insvc = 0;
        {e_valid, e_m2r, e_mw, e_rw, e_pcm, e_jal} = '0;
        e_dr = '0; e_d = '0; e_sr2 = '0; e_pc = '0; e_br = '0; e_ack = '0;
    endtask

    task automatic model_step();
        bit took, sq_now;
        int k;
        if (bus.stall_i) begin
            e_ack = '0;
            return;
        end
        sq_now  = m_sq > 0;
        took    = 0;
        e_valid = !sq_now && bus.in_valid_i;
        e_mw    = e_valid && bus.ctrl_i[3];
        e_rw    = e_valid && bus.ctrl_i[0];
        e_m2r   = bus.ctrl_i[4];
        e_dr    = bus.next_dr_i; e_d = bus.d_alu_i; e_sr2 = bus.sr2_i; e_pc = bus.pipe_pc_i;
        e_br = '0; e_pcm = 0; e_jal = 0; e_ack = '0;
        if (e_valid) begin
            if (bus.irq_i != 0 && !m_insvc) begin
                k = 0;
                while (!bus.irq_i[k]) k++;
                e_br = 32'(bus.iha_base_i + 32'(k * VS));
                e_ack[k] = 1'b1; m_insvc = 1; took = 1;
            end else if (bus.ctrl_i[2] && bus.d_alu_i != 0) begin
                e_br = bus.branch_i; took = 1;
            end else if (bus.ctrl_i[1]) begin
                e_br = bus.d_alu_i; e_jal = 1; took = 1;
            end else if (bus.ret_i) begin
                e_br = bus.ira_i; m_insvc = 0; took = 1;
            end
        end
        e_pcm = took;
        if (took) m_sq = FC;
        else if (m_sq > 0) m_sq--;
    endtask

    task automatic check_all();
        chk("ctl", {bus.out_valid_o, bus.mem_to_reg_o, bus.mem_write_o, bus.reg_write_o,
                    bus.pc_mux_o, bus.jal_o, bus.flush_o, bus.in_service_o},
                   {e_valid, e_m2r, e_mw, e_rw, e_pcm, e_jal, m_sq > 0, m_insvc});
        chk("ack", bus.irq_ack_o, e_ack);
        chk("br", bus.branch_o, e_br);
        chk("data", {bus.next_dr_o, bus.d_alu_o, bus.sr2_o, bus.pipe_pc_o}, {e_dr, e_d, e_sr2, e_pc});
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_in();
        bus.stall_i = 0; bus.in_valid_i = 0; bus.irq_i = '0; bus.next_dr_i = '0;
        bus.d_alu_i = '0; bus.sr2_i = '0; bus.branch_i = '0; bus.pipe_pc_i = '0;
        bus.ctrl_i = '0; bus.ret_i = 0; bus.ira_i = '0; bus.iha_base_i = '0;
    endtask

    task automatic rand_in();
        bus.stall_i    = $urandom_range(7) == 0;
        bus.in_valid_i = $urandom_range(7) != 0;
        bus.irq_i      = ($urandom_range(5) == 0) ? 4'($urandom) : 4'h0;
        bus.next_dr_i  = 4'($urandom);
        bus.d_alu_i    = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
        bus.sr2_i      = $urandom;
        bus.branch_i   = $urandom;
        bus.pipe_pc_i  = $urandom;
        bus.ctrl_i     = 5'($urandom);
        bus.ret_i      = $urandom_range(7) == 0;
        bus.ira_i      = $urandom;
        bus.iha_base_i = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 0;
        rand_in();
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    initial begin
        #1;
        do_reset();
        clear_in();
        bus.in_valid_i = 1; bus.ctrl_i = 5'b00001; bus.next_dr_i = 4'h7;
        step();
        chk("post_rst_valid", {bus.out_valid_o, bus.reg_write_o, bus.next_dr_o}, {2'b11, 4'h7});

        // taken branch, then a squash window of FC cycles
        clear_in();
        bus.in_valid_i = 1; bus.ctrl_i = 5'b00100; bus.d_alu_i = 1; bus.branch_i = 32'h100;
        step();
        chk("br_target", {bus.pc_mux_o, bus.jal_o, bus.branch_o}, {2'b10, 32'h100});
        chk("br_flush0", bus.flush_o, 1'b1);
        bus.ctrl_i = 5'b01001; bus.d_alu_i = 0;
        step();
        chk("br_flush1", {bus.flush_o, bus.out_valid_o, bus.mem_write_o, bus.reg_write_o}, 4'b1000);
        step();
        chk("br_flush2", {bus.flush_o, bus.out_valid_o, bus.mem_write_o, bus.reg_write_o}, 4'b0000);

        // IRQ beats a simultaneous taken branch
        clear_in();
        bus.in_valid_i = 1; bus.irq_i = 4'b0110; bus.iha_base_i = 32'h8000;
        bus.ctrl_i = 5'b00100; bus.d_alu_i = 1; bus.branch_i = 32'h200;
        step();
        chk("prio_br", bus.branch_o, 32'h8010);
        chk("prio_ack", {bus.irq_ack_o, bus.in_service_o}, {4'b0010, 1'b1});
        bus.irq_i = '0; bus.ctrl_i = '0; bus.d_alu_i = '0;
        step(); step();

        // interlock: IRQ blocked while in service, released by RETI
        bus.irq_i = 4'b0001;
        step();
        chk("lock_nored", {bus.pc_mux_o, bus.irq_ack_o, bus.in_service_o}, {1'b0, 4'b0, 1'b1});
        bus.ret_i = 1; bus.ira_i = 32'h44;
        step();
        chk("reti", {bus.pc_mux_o, bus.branch_o, bus.in_service_o}, {1'b1, 32'h44, 1'b0});
        bus.ret_i = 0;
        step(); step();
        step();
        chk("irq_after", {bus.pc_mux_o, bus.branch_o, bus.irq_ack_o}, {1'b1, 32'h8000, 4'b0001});
        bus.irq_i = '0;
        step(); step();
        bus.ret_i = 1; bus.ira_i = 32'h48;
        step();
        bus.ret_i = 0;
        step(); step();

        // stall freezes the squash window
        bus.ctrl_i = 5'b00010; bus.d_alu_i = 32'h300;
        step();
        chk("jalr", {bus.pc_mux_o, bus.jal_o, bus.branch_o}, {2'b11, 32'h300});
        bus.stall_i = 1; bus.ctrl_i = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", {bus.flush_o, bus.pc_mux_o, bus.jal_o, bus.branch_o}, {3'b111, 32'h300});
        end
        bus.stall_i = 0;
        step();
        chk("stall_rel1", {bus.flush_o, bus.pc_mux_o}, 2'b10);
        step();
        chk("stall_rel2", bus.flush_o, 1'b0);

        // vector address wraps modulo 2^32
        bus.irq_i = 4'b0010; bus.iha_base_i = 32'hFFFF_FFF0;
        step();
        chk("wrap", {bus.pc_mux_o, bus.branch_o, bus.irq_ack_o}, {1'b1, 32'h0, 4'b0010});

        // randomized traffic with occasional reset, sometimes inside a squash window
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) == 0) do_reset();
            rand_in();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
